// File: rtl/aes_block_dispatcher_pkg.sv
// rtl/aes_block_dispatcher_pkg.sv - shared types and sizing helpers for the AES block dispatcher
package aes_dispatch_package;

    localparam int BLOCK_W = 128;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } aes_pack_state_e;

    // $clog2(1) is 0, which would leave a single-lane or single-word pointer with no bits.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/aes_block_dispatcher_unpacker.sv
// rtl/aes_block_dispatcher_unpacker.sv - serialises one 128-bit result block into DW-bit output words
module aes_block_unpacker
    import aes_dispatch_package::*;
#(
    parameter int DW = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] load_data_i,
    output logic               can_load_o,
    output logic               empty_o,
    output logic [DW-1:0]      out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    localparam int WPB = BLOCK_W / DW;
    localparam int CW = ptr_width(WPB);
    localparam logic [CW-1:0] LAST_WORD = CW'(WPB - 1);

    logic [BLOCK_W-1:0] data_q, data_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               last_word;
    logic               out_fire;

    assign last_word   = (cnt_q == LAST_WORD);
    assign out_valid_o = valid_q && !clear_i;
    assign out_fire    = out_valid_o && out_ready_i;
    assign empty_o     = !valid_q;
    // A new block may land in the same cycle the final word leaves, so blocks stream without a gap.
    assign can_load_o  = !valid_q || (last_word && out_ready_i);

    always_comb begin
        out_data_o = data_q[DW-1:0];
        for (int k = 1; k < WPB; k++) begin
            if (cnt_q == CW'(k)) begin
                out_data_o = data_q[k*DW +: DW];
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (out_fire) begin
            if (last_word) begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (load_i) begin
            data_d  = load_data_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/aes_block_dispatcher.sv
// rtl/aes_block_dispatcher.sv - packs stream words into blocks, dispatches round-robin to AES lanes, reorders results
// Optional performance counters are enabled by defining AES_DISPATCH_PERF_EN.
module aes_block_dispatcher
    import aes_dispatch_package::*;
#(
    parameter int N_LANES         = 4,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              enable_i,
    input  logic [DW-1:0]                     in_data_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    output logic [N_LANES-1:0][BLOCK_W-1:0]   lane_data_o,
    output logic [N_LANES-1:0]                lane_valid_o,
    input  logic [N_LANES-1:0]                lane_ready_i,
    input  logic [N_LANES-1:0][BLOCK_W-1:0]   lane_res_i,
    input  logic [N_LANES-1:0]                lane_res_valid_i,
    output logic [N_LANES-1:0]                lane_res_ready_o,
    output logic [DW-1:0]                     out_data_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic                              busy_o
`ifdef AES_DISPATCH_PERF_EN
    ,
    output logic [31:0]                       perf_blocks_o,
    output logic [31:0]                       perf_stall_o
`endif
);

    localparam int WPB = BLOCK_W / DW;
    localparam int PW  = ptr_width(N_LANES);
    localparam int WW  = ptr_width(WPB);
    localparam int OW  = count_width(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_LANE = PW'(N_LANES - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(WPB - 1);
    localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);

    aes_pack_state_e    state_q, state_d;
    logic [WW-1:0]      word_cnt_q, word_cnt_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic [PW-1:0]      disp_ptr_q, disp_ptr_d;
    logic [PW-1:0]      col_ptr_q, col_ptr_d;
    logic [OW-1:0]      outstanding_q, outstanding_d;

    logic               kill;
    logic               can_dispatch;
    logic               in_fire;
    logic               disp_fire;
    logic               col_fire;
    logic               unpk_can_load;
    logic               unpk_empty;
    logic [BLOCK_W-1:0] col_data;

    // Reset and clear both suppress every handshake in the cycle they are asserted.
    assign kill         = rst_i || clear_i;
    assign can_dispatch = enable_i && (outstanding_q < MAX_OUT) && !kill;
    assign in_fire      = in_ready_o && in_valid_i;
    assign disp_fire    = |(lane_valid_o & lane_ready_i);
    assign col_fire     = |(lane_res_ready_o & lane_res_valid_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
        end else if (clear_i) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_fire && (word_cnt_q == LAST_WORD)) state_d = HOLD;
            HOLD:    if (disp_fire) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready_o   = 1'b0;
        lane_valid_o = '0;
        case (state_q)
            FILL: in_ready_o = enable_i && !kill;
            HOLD: begin
                for (int l = 0; l < N_LANES; l++) begin
                    lane_valid_o[l] = can_dispatch && (disp_ptr_q == PW'(l));
                end
            end
            default: in_ready_o = 1'b0;
        endcase
    end

    always_comb begin
        for (int l = 0; l < N_LANES; l++) begin
            lane_data_o[l]      = block_q;
            lane_res_ready_o[l] = !kill && (outstanding_q != '0) && unpk_can_load
                                  && (col_ptr_q == PW'(l));
        end
    end

    always_comb begin
        col_data = lane_res_i[0];
        for (int l = 1; l < N_LANES; l++) begin
            if (col_ptr_q == PW'(l)) begin
                col_data = lane_res_i[l];
            end
        end
    end

    always_comb begin
        word_cnt_d    = word_cnt_q;
        block_d       = block_q;
        disp_ptr_d    = disp_ptr_q;
        col_ptr_d     = col_ptr_q;
        outstanding_d = outstanding_q;
        if (in_fire) begin
            for (int k = 0; k < WPB; k++) begin
                if (word_cnt_q == WW'(k)) begin
                    block_d[k*DW +: DW] = in_data_i;
                end
            end
            word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + 1'b1;
        end
        if (disp_fire) begin
            disp_ptr_d = (disp_ptr_q == LAST_LANE) ? '0 : disp_ptr_q + 1'b1;
        end
        if (col_fire) begin
            col_ptr_d = (col_ptr_q == LAST_LANE) ? '0 : col_ptr_q + 1'b1;
        end
        case ({disp_fire, col_fire})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_cnt_q    <= '0;
            block_q       <= '0;
            disp_ptr_q    <= '0;
            col_ptr_q     <= '0;
            outstanding_q <= '0;
        end else if (clear_i) begin
            word_cnt_q    <= '0;
            block_q       <= '0;
            disp_ptr_q    <= '0;
            col_ptr_q     <= '0;
            outstanding_q <= '0;
        end else begin
            word_cnt_q    <= word_cnt_d;
            block_q       <= block_d;
            disp_ptr_q    <= disp_ptr_d;
            col_ptr_q     <= col_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

    aes_block_unpacker #(
        .DW (DW)
    ) u_unpacker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .load_i      (col_fire),
        .load_data_i (col_data),
        .can_load_o  (unpk_can_load),
        .empty_o     (unpk_empty),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    assign busy_o = (state_q == HOLD) || (word_cnt_q != '0) || (outstanding_q != '0) || !unpk_empty;

`ifdef AES_DISPATCH_PERF_EN
    logic [31:0] perf_blocks_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else if (clear_i) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (col_fire) perf_blocks_q <= perf_blocks_q + 32'd1;
            if ((state_q == HOLD) && !disp_fire) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_blocks_o = perf_blocks_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_aes_block_dispatcher.sv
// tb/tb_aes_block_dispatcher.sv - self-checking bench for aes_block_dispatcher
`timescale 1ns/1ps
module tb_aes_block_dispatcher;

    localparam int NL   = 4;
    localparam int MAXO = 8;

    typedef struct {
        logic [31:0] word;
        int          exp_lane;
        logic [31:0] exp_out;
    } vec_t;

    typedef struct {
        int           lane;
        logic [127:0] data;
        int           t;
    } pend_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clear, enable;

    logic [31:0]           in_data;
    logic                  in_valid, in_ready;
    logic [NL-1:0][127:0]  lane_data, lane_res;
    logic [NL-1:0]         lane_valid, lane_ready, lane_res_valid, lane_res_ready;
    logic [31:0]           out_data;
    logic                  out_valid, out_ready, busy;

    logic [127:0]          b_in_data, b_out_data;
    logic                  b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [0:0][127:0]     b_lane_data, b_lane_res;
    logic [0:0]            b_lane_valid, b_lane_ready, b_res_valid, b_res_ready;

    aes_block_dispatcher #(.N_LANES(NL), .DW(32), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .lane_data_o(lane_data), .lane_valid_o(lane_valid), .lane_ready_i(lane_ready),
        .lane_res_i(lane_res), .lane_res_valid_i(lane_res_valid), .lane_res_ready_o(lane_res_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
    );

    aes_block_dispatcher #(.N_LANES(1), .DW(128), .MAX_OUTSTANDING(2)) dut_w (
        .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .enable_i(enable),
        .in_data_i(b_in_data), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .lane_data_o(b_lane_data), .lane_valid_o(b_lane_valid), .lane_ready_i(b_lane_ready),
        .lane_res_i(b_lane_res), .lane_res_valid_i(b_res_valid), .lane_res_ready_o(b_res_ready),
        .out_data_o(b_out_data), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .busy_o(b_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: streams, expected blocks and words, lane contents.
    logic [31:0]  src_q[$];
    logic [31:0]  acc[$];
    logic [127:0] exp_blk[$];
    logic [31:0]  exp_out[$];
    pend_t        pend[$];
    int           lane_log[$];
    logic [31:0]  out_log[$];
    int           out_cyc[$];
    int           lane_delay[NL];
    bit           src_rand, lane_rand, out_rand, ret_en;
    logic [NL-1:0] lane_mask;
    int           disp_count, inflight, cyc;
    logic [NL-1:0] lv_s;
    logic         ir_s, busy_s;
    vec_t         vec[16];

    task automatic model_reset();
        src_q.delete(); acc.delete(); exp_blk.delete(); exp_out.delete(); pend.delete();
        lane_log.delete(); out_log.delete(); out_cyc.delete();
        disp_count = 0;
        inflight   = 0;
        in_valid = 1'b0; in_data = '0;
        lane_res_valid = '0; lane_res = '0;
    endtask

    task automatic step();
        bit in_f, out_f;
        logic [NL-1:0] df, cf;
        @(negedge clk);
        lv_s = lane_valid; ir_s = in_ready; busy_s = busy;
        in_f  = in_valid && in_ready;
        out_f = out_valid && out_ready;
        df    = lane_valid & lane_ready;
        cf    = lane_res_valid & lane_res_ready;
        chk("onehot_valid", $countones(lane_valid) <= 1, 1);
        if (in_f) begin
            void'(src_q.pop_front());
            acc.push_back(in_data);
            exp_out.push_back(in_data);
            if (acc.size() == 4) begin
                exp_blk.push_back({acc[3], acc[2], acc[1], acc[0]});
                acc.delete();
            end
        end
        for (int l = 0; l < NL; l++) begin
            if (df[l]) begin
                chk("disp_lane", l, disp_count % NL);
                chk("disp_pending", exp_blk.size() > 0, 1);
                if (exp_blk.size() > 0) chk("disp_data", lane_data[l], exp_blk.pop_front());
                pend.push_back('{l, lane_data[l], cyc + lane_delay[l]});
                lane_log.push_back(l);
                disp_count++;
                inflight++;
                chk("inflight_max", inflight <= MAXO, 1);
            end
            if (cf[l]) begin
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].lane == l) begin
                        pend.delete(i);
                        break;
                    end
                end
                inflight--;
            end
        end
        if (out_f) begin
            chk("out_pending", exp_out.size() > 0, 1);
            if (exp_out.size() > 0) chk("out_word", out_data, exp_out.pop_front());
            out_log.push_back(out_data);
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (in_f || !in_valid) begin
            in_valid = (src_q.size() > 0) && (!src_rand || $urandom_range(3) != 0);
            in_data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
        for (int l = 0; l < NL; l++) begin
            lane_ready[l]     = lane_mask[l] && (!lane_rand || $urandom_range(1) == 1);
            lane_res_valid[l] = 1'b0;
            lane_res[l]       = '0;
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].lane == l) begin
                    if (ret_en && cyc >= pend[i].t) begin
                        lane_res_valid[l] = 1'b1;
                        lane_res[l]       = pend[i].data;
                    end
                    break;
                end
            end
        end
        out_ready = !out_rand || ($urandom_range(1) == 1);
    endtask

    task automatic drain(input int limit, input string name);
        int n = 0;
        while ((src_q.size() > 0 || acc.size() > 0 || exp_out.size() > 0 || inflight > 0) && n < limit) begin
            step();
            n++;
        end
        chk(name, n < limit, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; clear = 1'b0; enable = 1'b1;
        lane_ready = '0; out_ready = 1'b1;
        b_in_data = '0; b_in_valid = 1'b0; b_lane_ready = '0; b_lane_res = '0;
        b_res_valid = '0; b_out_ready = 1'b0;
        src_rand = 0; lane_rand = 0; out_rand = 0; ret_en = 1; lane_mask = '1;
        cyc = 0;
        lane_delay = '{8, 1, 2, 3};
        model_reset();
        for (int i = 0; i < 16; i++) vec[i] = '{32'(i), (i / 4) % 4, 32'(i)};

        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_lane_valid", lane_valid, 0);
        chk("rst_res_ready", lane_res_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lane_data", lane_data[0], 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        chk("rst_b_lane_data", b_lane_data[0], 0);
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b0;
        @(negedge clk);
        chk("en_low_in_ready", in_ready, 0);
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        chk("en_high_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Ordered stream through lanes with lane 0 slowest.
        for (int i = 0; i < 16; i++) src_q.push_back(vec[i].word);
        drain(600, "t1_drain");
        chk("t1_out_count", out_log.size(), 16);
        for (int i = 0; i < out_log.size(); i++) begin
            chk("t1_out", out_log[i], vec[i].exp_out);
            if (i % 4 == 0 && lane_log.size() > i / 4) chk("t1_lane", lane_log[i / 4], vec[i].exp_lane);
        end

        // Stall lane 1 with the second block pending.
        lane_log.delete(); out_log.delete();
        lane_mask = 4'b1101;
        for (int i = 0; i < 12; i++) src_q.push_back(32'h100 + i);
        n = 0;
        do begin step(); n++; end while (!lv_s[1] && n < 100);
        chk("t2_wait_lane1", lv_s[1], 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t2_hold_valid", lv_s, 4'b0010);
            chk("t2_in_ready", ir_s, 0);
        end
        lane_mask = '1;
        drain(600, "t2_drain");
        chk("t2_blocks", lane_log.size(), 3);

        // Results all waiting in lanes: output must be continuous.
        ret_en = 0;
        for (int i = 0; i < 16; i++) src_q.push_back(32'h200 + i);
        n = 0;
        while ((inflight < 4 || src_q.size() > 0) && n < 300) begin step(); n++; end
        chk("t3_fill", inflight, 4);
        out_cyc.delete();
        ret_en = 1;
        drain(300, "t3_drain");
        chk("t3_count", out_cyc.size(), 16);
        if (out_cyc.size() == 16) chk("t3_no_bubble", out_cyc[15] - out_cyc[0], 15);

        // Clear after two of four words.
        src_q.push_back(32'hA0); src_q.push_back(32'hA1);
        n = 0;
        while (acc.size() < 2 && n < 50) begin step(); n++; end
        chk("t4_partial_busy", busy_s, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        step();
        chk("t4_busy_after_clear", busy_s, 0);
        for (int i = 0; i < 4; i++) src_q.push_back(32'hB0 + i);
        drain(200, "t4_drain");
        chk("t4_blocks", lane_log.size(), 1);
        if (lane_log.size() > 0) chk("t4_lane0", lane_log[0], 0);

        // Randomised traffic.
        src_rand = 1; lane_rand = 1; out_rand = 1;
        lane_delay[0] = $urandom_range(15, 5);
        for (int l = 1; l < NL; l++) lane_delay[l] = $urandom_range(6, 0);
        out_log.delete();
        for (int i = 0; i < 64; i++) src_q.push_back($urandom);
        drain(4000, "t5_drain");
        chk("t5_out_count", out_log.size(), 64);

        // Wide single-lane instance, two outstanding at most.
        b_in_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888; b_in_valid = 1'b1;
        @(negedge clk); chk("b_in_ready", b_in_ready, 1);
        @(posedge clk); #1; b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_lane_valid1", b_lane_valid, 1);
        chk("b_lane_data1", b_lane_data[0], 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        chk("b_in_ready_hold", b_in_ready, 0);
        @(posedge clk); #1; b_lane_ready = 1'b1;
        @(posedge clk); #1; b_lane_ready = 1'b0;
        b_in_data = 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0002; b_in_valid = 1'b1;
        @(posedge clk); #1; b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_lane_valid2", b_lane_valid, 1);
        chk("b_lane_data2", b_lane_data[0], 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0002);
        @(posedge clk); #1; b_lane_ready = 1'b1;
        @(posedge clk); #1; b_lane_ready = 1'b0;
        b_in_data = 128'h3333_3333_3333_3333_3333_3333_3333_3333; b_in_valid = 1'b1;
        @(posedge clk); #1; b_in_valid = 1'b0; b_lane_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("b_max_valid", b_lane_valid, 0);
            chk("b_max_busy", b_busy, 1);
            chk("b_max_in_ready", b_in_ready, 0);
        end
        @(posedge clk); #1;
        b_lane_ready = 1'b0;
        b_lane_res[0] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE; b_res_valid = 1'b1;
        @(negedge clk); chk("b_res_ready", b_res_ready, 1);
        @(posedge clk); #1; b_res_valid = 1'b0;
        @(negedge clk);
        chk("b_out_valid", b_out_valid, 1);
        chk("b_out_data", b_out_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        chk("b_lane_valid3", b_lane_valid, 1);
        chk("b_lane_data3", b_lane_data[0], 128'h3333_3333_3333_3333_3333_3333_3333_3333);
        chk("b_res_ready_full", b_res_ready, 0);
        @(posedge clk); #1; b_out_ready = 1'b1;
        @(posedge clk); #1; b_out_ready = 1'b0;
        @(negedge clk);
        chk("b_out_drained", b_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
